// File: rtl/rcc_pkg.sv
// Shared types and defaults for the RCC bus clock-enable generator.
package rcc_pkg;

  localparam int RCC_MAX_LOG2 = 9;
  localparam int RCC_IDLE_CYC = 4;

  typedef enum logic [1:0] {
    DOM_RUN       = 2'd0,
    DOM_IDLE_WAIT = 2'd1,
    DOM_GATED     = 2'd2,
    DOM_WAKE      = 2'd3
  } dom_state_e;

  // Exponents above the counter width would never see a boundary, so saturate.
  function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned max_log2);
    return (sel > max_log2) ? max_log2 : sel;
  endfunction

endpackage

// File: rtl/rcc_bus_clk_en_gen_dom_gate_fsm.sv
// Per-domain sleep gating FSM: idle qualification, gating and the registered enable pulse.
module rcc_dom_gate_fsm
  import rcc_pkg::*;
#(
  parameter int IDLE_CYC = RCC_IDLE_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bnd,
  input  logic       sleep_req,
  input  logic       busy,
  output logic       clk_en,
  output logic       sleep_ack,
  output dom_state_e state
);

  localparam int IW = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
  localparam logic [IW-1:0] IDLE_LOAD = IW'(IDLE_CYC - 1);

  dom_state_e    state_nxt;
  logic [IW-1:0] idle_cnt;
  logic [IW-1:0] idle_nxt;
  logic          en_nxt;

  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    // WAKE pulses on its boundary too, so only GATED suppresses the enable.
    en_nxt    = bnd & (state != DOM_GATED);
    unique case (state)
      DOM_RUN: begin
        if (sleep_req & ~busy) begin
          state_nxt = DOM_IDLE_WAIT;
          idle_nxt  = IDLE_LOAD;
        end
      end
      DOM_IDLE_WAIT: begin
        if (busy | ~sleep_req) begin
          state_nxt = DOM_RUN;
        end else if (idle_cnt == '0) begin
          if (bnd) state_nxt = DOM_GATED;
        end else begin
          idle_nxt = idle_cnt - IW'(1);
        end
      end
      DOM_GATED: begin
        if (~sleep_req | busy) state_nxt = DOM_WAKE;
      end
      DOM_WAKE: begin
        if ((sleep_req & ~busy) | bnd) state_nxt = DOM_RUN;
      end
      default: state_nxt = DOM_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DOM_RUN;
      idle_cnt <= '0;
      clk_en   <= 1'b0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_nxt;
      clk_en   <= en_nxt;
    end
  end

  assign sleep_ack = (state == DOM_GATED);

endmodule

// File: rtl/rcc_bus_clk_en_gen.sv
// Bus clock-enable generator: shared master counter, coherent prescaler update, one gate FSM per domain.
module rcc_bus_clk_en_gen
  import rcc_pkg::*;
#(
  parameter int NUM_DOM  = 3,
  parameter int MAX_LOG2 = RCC_MAX_LOG2,
  parameter int SEL_W    = $clog2(MAX_LOG2 + 1),
  parameter int IDLE_CYC = RCC_IDLE_CYC,
  parameter int RST_SEL  = 0
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [NUM_DOM*SEL_W-1:0] div_sel,
  input  logic                     div_upd,
  output logic                     div_upd_busy,
  input  logic [NUM_DOM-1:0]       dom_sleep_req,
  input  logic [NUM_DOM-1:0]       dom_busy,
  output logic [NUM_DOM-1:0]       dom_clk_en,
  output logic [NUM_DOM-1:0]       dom_sleep_ack,
  output logic [2*NUM_DOM-1:0]     dom_state_dbg
);

  localparam logic [SEL_W-1:0] RST_SEL_C = SEL_W'(clamp_sel(RST_SEL, MAX_LOG2));

  logic [MAX_LOG2-1:0] cnt;
  logic                upd_busy;
  logic                apply;
  logic [SEL_W-1:0]    cap_sel  [NUM_DOM];
  logic [SEL_W-1:0]    pend_sel [NUM_DOM];
  logic [SEL_W-1:0]    act_sel  [NUM_DOM];
  logic [MAX_LOG2-1:0] bnd_mask [NUM_DOM];
  logic [NUM_DOM-1:0]  bnd;

  // All-ones is a boundary for every ratio, so swapping selects here keeps domains phase-aligned.
  assign apply = &cnt;

  always_comb begin
    for (int d = 0; d < NUM_DOM; d++) begin
      cap_sel[d]  = SEL_W'(clamp_sel(32'(div_sel[d*SEL_W +: SEL_W]), MAX_LOG2));
      bnd_mask[d] = MAX_LOG2'((32'd1 << act_sel[d]) - 32'd1);
      bnd[d]      = (cnt & bnd_mask[d]) == bnd_mask[d];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt      <= '0;
      upd_busy <= 1'b0;
      for (int d = 0; d < NUM_DOM; d++) begin
        pend_sel[d] <= '0;
        act_sel[d]  <= RST_SEL_C;
      end
    end else begin
      cnt <= cnt + MAX_LOG2'(1);
      if (apply) begin
        upd_busy <= 1'b0;
        for (int d = 0; d < NUM_DOM; d++) begin
          if (div_upd)       act_sel[d] <= cap_sel[d];
          else if (upd_busy) act_sel[d] <= pend_sel[d];
        end
      end else if (div_upd) begin
        upd_busy <= 1'b1;
      end
      if (div_upd) begin
        for (int d = 0; d < NUM_DOM; d++) pend_sel[d] <= cap_sel[d];
      end
    end
  end

  assign div_upd_busy = upd_busy;

  for (genvar d = 0; d < NUM_DOM; d++) begin : g_dom
    dom_state_e st;

    rcc_dom_gate_fsm #(
      .IDLE_CYC (IDLE_CYC)
    ) u_fsm (
      .clk       (sys_clk),
      .rst       (sys_rst),
      .bnd       (bnd[d]),
      .sleep_req (dom_sleep_req[d]),
      .busy      (dom_busy[d]),
      .clk_en    (dom_clk_en[d]),
      .sleep_ack (dom_sleep_ack[d]),
      .state     (st)
    );

    assign dom_state_dbg[2*d +: 2] = st;
  end

endmodule

// File: tb/tb_rcc_bus_clk_en_gen.sv
// Bench for rcc_bus_clk_en_gen with the default parameter set (3 domains, 9-bit counter).
module tb_rcc_bus_clk_en_gen;
  import rcc_pkg::*;

  logic        sys_clk;
  logic        sys_rst;
  logic [11:0] div_sel;
  logic        div_upd;
  logic        div_upd_busy;
  logic [2:0]  dom_sleep_req;
  logic [2:0]  dom_busy;
  logic [2:0]  dom_clk_en;
  logic [2:0]  dom_sleep_ack;
  logic [5:0]  dom_state_dbg;

  rcc_bus_clk_en_gen dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .div_sel       (div_sel),
    .div_upd       (div_upd),
    .div_upd_busy  (div_upd_busy),
    .dom_sleep_req (dom_sleep_req),
    .dom_busy      (dom_busy),
    .dom_clk_en    (dom_clk_en),
    .dom_sleep_ack (dom_sleep_ack),
    .dom_state_dbg (dom_state_dbg)
  );

  // clock / reset
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  typedef struct {
    logic [2:0] slp;
    logic [2:0] bsy;
    logic [2:0] ack;
    logic [2:0] en;
  } vec_t;

  vec_t       tbl [11];
  logic [6:0] exp_q [$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         k0 = 0;
  int         k1 = 0;
  int         k2 = 0;

  // Expected enables for the cycle whose counter value is c, from the ratio exponents in force.
  function automatic logic [2:0] cad(input int c);
    int cn;
    logic [2:0] r;
    cn   = c % 512;
    r[0] = (cn % (1 << k0)) == 0;
    r[1] = (cn % (1 << k1)) == 0;
    r[2] = (cn % (1 << k2)) == 0;
    return r;
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
    end
  endtask

  // Drives one cycle; the expected {busy, ack, en} after the edge is queued, then compared.
  task automatic step(input logic upd, input logic [11:0] sel, input logic [2:0] slp,
                      input logic [2:0] bsy, input logic [6:0] exp_v, input string name);
    logic [6:0] want;
    div_upd       = upd;
    div_sel       = sel;
    dom_sleep_req = slp;
    dom_busy      = bsy;
    exp_q.push_back(exp_v);
    @(posedge sys_clk);
    #1;
    cyc++;
    div_upd = 1'b0;
    want = exp_q.pop_front();
    check(name, {div_upd_busy, dom_sleep_ack, dom_clk_en}, want);
  endtask

  task automatic run_to(input int target, input logic ub, input logic [2:0] slp,
                        input logic [2:0] bsy, input logic [2:0] ack, input logic [2:0] mask,
                        input string name);
    while (cyc < target)
      step(1'b0, 12'd0, slp, bsy, {ub, ack, cad(cyc + 1) & mask}, name);
  endtask

  initial begin
    //            slp     bsy     ack     en
    tbl[0]  = '{3'b000, 3'b000, 3'b000, 3'b111};
    tbl[1]  = '{3'b100, 3'b100, 3'b000, 3'b111};
    tbl[2]  = '{3'b001, 3'b000, 3'b000, 3'b111};
    tbl[3]  = '{3'b001, 3'b000, 3'b000, 3'b111};
    tbl[4]  = '{3'b001, 3'b000, 3'b000, 3'b111};
    tbl[5]  = '{3'b001, 3'b000, 3'b000, 3'b111};
    tbl[6]  = '{3'b001, 3'b000, 3'b001, 3'b111};
    tbl[7]  = '{3'b001, 3'b000, 3'b001, 3'b110};
    tbl[8]  = '{3'b001, 3'b001, 3'b000, 3'b110};
    tbl[9]  = '{3'b001, 3'b001, 3'b000, 3'b111};
    tbl[10] = '{3'b000, 3'b000, 3'b000, 3'b111};

    sys_rst       = 1'b1;
    div_upd       = 1'b0;
    div_sel       = '0;
    dom_sleep_req = '0;
    dom_busy      = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_outs", {div_upd_busy, dom_sleep_ack, dom_clk_en}, 7'd0);
    sys_rst = 1'b0;
    cyc     = 0;
    check("first_cycle", {div_upd_busy, dom_sleep_ack, dom_clk_en}, 7'd0);

    // sel=0 cadence plus dom0 sleep entry and busy wake at full rate
    for (int i = 0; i < 11; i++)
      step(1'b0, 12'd0, tbl[i].slp, tbl[i].bsy, {1'b0, tbl[i].ack, tbl[i].en}, "table");

    // update {2,1,3} captured at cnt=100, applied at the wrap
    run_to(100, 1'b0, 3'b000, 3'b000, 3'b000, 3'b111, "pre_upd");
    step(1'b1, {4'd2, 4'd1, 4'd3}, 3'b000, 3'b000, {1'b1, 3'b000, cad(cyc + 1)}, "upd_capture");
    run_to(511, 1'b1, 3'b000, 3'b000, 3'b000, 3'b111, "upd_pending");
    k0 = 3; k1 = 1; k2 = 2;
    run_to(552, 1'b0, 3'b000, 3'b000, 3'b000, 3'b111, "ratio_213");

    // two captures before the wrap: latest wins, dom2 value 15 clamps to 9
    run_to(560, 1'b0, 3'b000, 3'b000, 3'b000, 3'b111, "ratio_213");
    step(1'b1, {4'd4, 4'd4, 4'd3}, 3'b000, 3'b000, {1'b1, 3'b000, cad(cyc + 1)}, "upd_first");
    run_to(600, 1'b1, 3'b000, 3'b000, 3'b000, 3'b111, "upd_busy_hold");
    step(1'b1, {4'd15, 4'd2, 4'd5}, 3'b000, 3'b000, {1'b1, 3'b000, cad(cyc + 1)}, "upd_second");
    run_to(1023, 1'b1, 3'b000, 3'b000, 3'b000, 3'b111, "upd_busy_hold");
    k0 = 5; k1 = 2; k2 = 9;
    run_to(1030, 1'b0, 3'b000, 3'b000, 3'b000, 3'b111, "ratio_latest");

    // dom1 at sel=2: sleep entry, then busy wake with the request still held
    run_to(1035, 1'b0, 3'b010, 3'b000, 3'b000, 3'b111, "dom1_idle_wait");
    run_to(1036, 1'b0, 3'b010, 3'b000, 3'b010, 3'b111, "dom1_final_pulse");
    run_to(1048, 1'b0, 3'b010, 3'b000, 3'b010, 3'b101, "dom1_gated");
    check("dom1_state_gated", {5'd0, dom_state_dbg[3:2]}, {5'd0, DOM_GATED});
    run_to(1060, 1'b0, 3'b010, 3'b010, 3'b000, 3'b111, "dom1_busy_wake");
    check("dom1_state_run", {5'd0, dom_state_dbg[3:2]}, {5'd0, DOM_RUN});
    run_to(1070, 1'b0, 3'b000, 3'b000, 3'b000, 3'b111, "dom1_release");

    // capture on the apply cycle takes effect at once, busy never shows
    run_to(1535, 1'b0, 3'b000, 3'b000, 3'b000, 3'b111, "pre_coincide");
    step(1'b1, {4'd1, 4'd1, 4'd1}, 3'b000, 3'b000, {1'b0, 3'b000, cad(cyc + 1)}, "upd_coincide");
    k0 = 1; k1 = 1; k2 = 1;
    run_to(1545, 1'b0, 3'b000, 3'b000, 3'b000, 3'b111, "ratio_111");

    // dom0 gated with an update pending, then reset
    run_to(1549, 1'b0, 3'b001, 3'b000, 3'b000, 3'b111, "dom0_idle_wait");
    run_to(1550, 1'b0, 3'b001, 3'b000, 3'b001, 3'b111, "dom0_final_pulse");
    run_to(1556, 1'b0, 3'b001, 3'b000, 3'b001, 3'b110, "dom0_gated");
    step(1'b1, {4'd3, 4'd3, 4'd3}, 3'b001, 3'b000, {1'b1, 3'b001, cad(cyc + 1) & 3'b110}, "upd_gated");
    run_to(1560, 1'b1, 3'b001, 3'b000, 3'b001, 3'b110, "dom0_gated_pend");
    sys_rst = 1'b1;
    step(1'b0, 12'd0, 3'b001, 3'b000, 7'd0, "rst_assert");
    step(1'b0, 12'd0, 3'b001, 3'b000, 7'd0, "rst_hold");
    sys_rst = 1'b0;
    cyc = 0;
    k0 = 0; k1 = 0; k2 = 0;
    check("rst_states", {1'b0, dom_state_dbg}, 7'd0);
    run_to(520, 1'b0, 3'b000, 3'b000, 3'b000, 3'b111, "rst_cadence");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
